// File: rtl/alu_mul_seq_if.sv
// alu_mul_seq_if: requester start/busy/done handshake plus the drive lines to the shared ALU
interface alu_mul_seq_if;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  alu_aluop;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [15:0] alu_f;

    modport master (
        output start, op_a, op_b, alu_f,
        input  busy, done, result, alu_aluop, alu_a, alu_b
    );

    modport slave (
        input  start, op_a, op_b, alu_f,
        output busy, done, result, alu_aluop, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-and-add 16x16 multiplier (low 16 bits) that borrows a multiplier-less LC-3b ALU
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [3:0] {
        alu_add, alu_and, alu_not, alu_pass, alu_sll, alu_srl, alu_sra
    } lc3b_aluop;
endpackage

module alu_mul_seq
    import lc3b_types::*;
#(
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic         clk,
    input logic         reset,
    alu_mul_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, CHECK, ADD, SLL, SRL, DONE} state_t;

    state_t     state_q, state_d;
    lc3b_word   acc_q, acc_d;
    lc3b_word   mcand_q, mcand_d;
    lc3b_word   mplier_q, mplier_d;
    lc3b_word   result_q, result_d;
    logic [4:0] iter_q, iter_d;
    lc3b_aluop  aluop;
    lc3b_word   alu_a, alu_b;

    // state and datapath registers; reset aborts any multiply and clears the result
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            result_q <= '0;
            iter_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            result_q <= result_d;
            iter_q   <= iter_d;
        end
    end

    // sequencing and ALU drive; the ALU sees alu_pass with zero operands whenever we are not using it
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        result_d = result_q;
        iter_d   = iter_q;
        aluop    = alu_pass;
        alu_a    = '0;
        alu_b    = '0;
        case (state_q)
            IDLE: if (bus.start) begin
                acc_d    = '0;
                mcand_d  = bus.op_a;
                mplier_d = bus.op_b;
                iter_d   = '0;
                state_d  = CHECK;
            end
            CHECK: if ((EARLY_EXIT && mplier_q == '0) || iter_q == 5'd16) begin
                // acc is final here and unchanged in DONE, so load result now to have it valid alongside done
                result_d = acc_q;
                state_d  = DONE;
            end else begin
                state_d  = mplier_q[0] ? ADD : SLL;
            end
            ADD: begin
                aluop   = alu_add;
                alu_a   = acc_q;
                alu_b   = mcand_q;
                acc_d   = bus.alu_f;
                state_d = SLL;
            end
            SLL: begin
                aluop   = alu_sll;
                alu_a   = mcand_q;
                alu_b   = 16'h0001;
                mcand_d = bus.alu_f;
                state_d = SRL;
            end
            SRL: begin
                aluop    = alu_srl;
                alu_a    = mplier_q;
                alu_b    = 16'h0001;
                mplier_d = bus.alu_f;
                iter_d   = iter_q + 5'd1;
                state_d  = CHECK;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy      = state_q != IDLE;
    assign bus.done      = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.alu_aluop = aluop;
    assign bus.alu_a     = alu_a;
    assign bus.alu_b     = alu_b;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed checks of the multiply sequencer against a behavioural LC-3b ALU
module tb_alu_mul_seq;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] last_res [2];

    alu_mul_seq_if b1 ();
    alu_mul_seq_if b0 ();

    alu_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    alu_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    always #5 clk = ~clk;

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            alu_add: return a + b;
            alu_and: return a & b;
            alu_not: return ~a;
            alu_sll: return a << b[3:0];
            alu_srl: return a >> b[3:0];
            alu_sra: return $signed(a) >>> b[3:0];
            default: return a;
        endcase
    endfunction

    assign b1.alu_f = alu(b1.alu_aluop, b1.alu_a, b1.alu_b);
    assign b0.alu_f = alu(b0.alu_aluop, b0.alu_a, b0.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (!reset) chk("iter_bound", {31'd0, dut1.iter_q > 5'd16}, 32'd0);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit e, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (e) begin
            b1.start = s; b1.op_a = a; b1.op_b = b;
        end else begin
            b0.start = s; b0.op_a = a; b0.op_b = b;
        end
    endtask

    // accept a request, wait for done, check latency/result, then the return to idle
    task automatic run(input bit e, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input int n, input bit hold, input string tag);
        int cyc;
        drive(e, 1'b1, a, b);
        step();
        chk({tag, "_busy"}, e ? b1.busy : b0.busy, 1);
        if (!hold) drive(e, 1'b0, a, b);
        cyc = 1;
        while (!(e ? b1.done : b0.done) && cyc < 300) begin
            chk({tag, "_held"}, e ? b1.result : b0.result, last_res[e]);
            if (hold) drive(e, 1'b1, 16'($urandom), 16'($urandom));
            step();
            cyc++;
        end
        chk({tag, "_cycles"}, cyc, n);
        chk({tag, "_result"}, e ? b1.result : b0.result, exp);
        last_res[e] = exp;
        step();
        chk({tag, "_busy_drop"}, e ? b1.busy : b0.busy, 0);
        chk({tag, "_done_drop"}, e ? b1.done : b0.done, 0);
        chk({tag, "_result_hold"}, e ? b1.result : b0.result, exp);
    endtask

    initial begin
        last_res[0] = '0;
        last_res[1] = '0;
        drive(1, 1'b0, '0, '0);
        drive(0, 1'b0, '0, '0);
        repeat (3) step();
        chk("rst_busy", b1.busy, 0);
        chk("rst_done", b1.done, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_result", b1.result, 0);
            chk("idle_done", b1.done, 0);
            chk("idle_busy", b1.busy, 0);
            chk("idle_aluop", b1.alu_aluop, alu_pass);
            chk("idle_a", b1.alu_a, 0);
        end
        run(1, 16'd3, 16'd5, 16'h000F, 13, 0, "m3x5");
        run(1, 16'h1234, 16'h0000, 16'h0000, 2, 0, "mx0");
        run(1, 16'h0000, 16'h00FF, 16'h0000, 34, 0, "m0xff");
        run(1, 16'hFFFF, 16'hFFFF, 16'h0001, 66, 0, "mffff");
        run(1, 16'hFFFD, 16'h0007, 16'hFFEB, 14, 0, "mneg3x7");
        run(1, 16'd2, 16'd3, 16'h0006, 10, 1, "hold1");
        run(1, 16'd4, 16'd3, 16'h000C, 10, 0, "hold2");
        drive(1, 1'b1, 16'd7, 16'd9);
        step();
        drive(1, 1'b0, 16'd7, 16'd9);
        chk("rst_run_busy", b1.busy, 1);
        step();
        chk("add_aluop", b1.alu_aluop, alu_add);
        chk("add_a", b1.alu_a, 0);
        chk("add_b", b1.alu_b, 7);
        step();
        chk("sll_aluop", b1.alu_aluop, alu_sll);
        chk("sll_a", b1.alu_a, 7);
        chk("sll_b", b1.alu_b, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        last_res[1] = '0;
        chk("abort_busy", b1.busy, 0);
        chk("abort_result", b1.result, 0);
        for (int i = 0; i < 20; i++) begin
            chk("abort_nodone", b1.done, 0);
            step();
        end
        run(1, 16'd7, 16'd9, 16'h003F, 16, 0, "m7x9");
        run(0, 16'd3, 16'd2, 16'h0006, 51, 0, "fixed3x2");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
